// File: rtl/button_event_if.sv
// Signal bundle between the debouncer bank, the button event arbiter and the event consumer.
// evt_ts and TS_W exist only when BTN_EVT_TIMESTAMP_EN is defined.
interface button_event_if #(
  parameter int N_BTN = 4
`ifdef BTN_EVT_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
);
  localparam int ID_W = $clog2(N_BTN);

  logic [N_BTN-1:0] btn_pulse;
  logic             evt_valid;
  logic             evt_ready;
  logic [ID_W-1:0]  evt_id;
  logic [N_BTN-1:0] pending;
  logic             overflow;
  logic             clr_overflow;
`ifdef BTN_EVT_TIMESTAMP_EN
  logic [TS_W-1:0]  evt_ts;
`endif

  // master drives presses and consumes events; slave is the arbiter
  modport master (
    output btn_pulse, evt_ready, clr_overflow,
    input  evt_valid, evt_id, pending, overflow
`ifdef BTN_EVT_TIMESTAMP_EN
    , input evt_ts
`endif
  );

  modport slave (
    input  btn_pulse, evt_ready, clr_overflow,
    output evt_valid, evt_id, pending, overflow
`ifdef BTN_EVT_TIMESTAMP_EN
    , output evt_ts
`endif
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Latches debounced button presses, arbitrates them round-robin into an event FIFO.
// Optional per-event press timestamps are enabled by defining BTN_EVT_TIMESTAMP_EN.
module button_event_arbiter #(
  parameter int N_BTN = 4,
  parameter int DEPTH = 8
`ifdef BTN_EVT_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input logic               clk,
  input logic               rst,
  button_event_if.slave     bus
);
  localparam int ID_W  = $clog2(N_BTN);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N_BTN-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [ID_W-1:0]  last_grant_q;
  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic             grant;
  logic             pop;
  logic [N_BTN-1:0] granted_vec;
  logic [N_BTN-1:0] still_pending;

  // Round-robin search starting one past the last granted index
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      if (!grant_found && pending_q[(int'(last_grant_q) + k) % N_BTN]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(last_grant_q) + k) % N_BTN);
      end
    end
  end

  // Full check uses the registered count only, so a same-cycle pop never frees a slot
  always_comb begin
    grant         = grant_found && (count_q < CNT_W'(DEPTH));
    pop           = (count_q != '0) && bus.evt_ready;
    granted_vec   = grant ? (N_BTN'(1) << grant_id) : '0;
    still_pending = pending_q & ~granted_vec;
    pending_d     = still_pending | bus.btn_pulse;
    overflow_d    = overflow_q;
    if (|(bus.btn_pulse & still_pending)) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
    count_d = count_q;
    if (grant && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !grant) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      last_grant_q <= ID_W'(N_BTN - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      if (grant) begin
        mem_q[wr_ptr_q] <= grant_id;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        last_grant_q    <= grant_id;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

`ifdef BTN_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [TS_W-1:0] ts_hold_q [N_BTN];
  logic [TS_W-1:0] mem_ts_q  [DEPTH];

  // A coalesced press keeps its original stamp; a fresh or re-armed press takes a new one
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        ts_hold_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        mem_ts_q[i] <= '0;
      end
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      for (int i = 0; i < N_BTN; i++) begin
        if (bus.btn_pulse[i] && !still_pending[i]) begin
          ts_hold_q[i] <= ts_cnt_q;
        end
      end
      if (grant) begin
        mem_ts_q[wr_ptr_q] <= ts_hold_q[grant_id];
      end
    end
  end

  assign bus.evt_ts = mem_ts_q[rd_ptr_q];
`endif

  assign bus.evt_valid = (count_q != '0);
  assign bus.evt_id    = mem_q[rd_ptr_q];
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: expected IDs are queued as presses are driven
// and checked as the FIFO head is consumed.
`timescale 1ns/1ps
module tb_button_event_arbiter;
  localparam int N_BTN = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [1:0] expQ [$];

  button_event_if #(.N_BTN(N_BTN)) bus ();

  button_event_arbiter #(.N_BTN(N_BTN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.btn_pulse    = '0;
    bus.evt_ready    = 1'b0;
    bus.clr_overflow = 1'b0;
    tick();
    rst = 1'b0;
    expQ.delete();
  endtask

  // Consume events with ready held high, comparing each head against the scoreboard
  task automatic drain(input string tag, input int budget);
    logic [1:0] expId;
    bus.evt_ready = 1'b1;
    for (int c = 0; c < budget && expQ.size() != 0; c++) begin
      if (bus.evt_valid) begin
        expId = expQ.pop_front();
        vectors++;
        if (bus.evt_id !== expId) begin
          miscompares++;
          $display("[TB] FAIL %s_id: got %0d expected %0d", tag, bus.evt_id, expId);
        end
      end
      tick();
    end
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: got %0d events left expected 0", tag, expQ.size());
      expQ.delete();
    end
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 4;
    if (bus.evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.evt_valid); end
    if (bus.pending !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_pending: got %b expected 0000", bus.pending); end
    if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %0b expected 0", bus.overflow); end
    if (bus.evt_id !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_id: got %0d expected 0", bus.evt_id); end
  endtask

  task automatic test_single_press();
    logic [1:0] expId;
    bus.evt_ready = 1'b1;
    bus.btn_pulse = 4'b0100;
    expQ.push_back(2'd2);
    tick();
    bus.btn_pulse = '0;
    vectors += 2;
    if (bus.evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early_valid: got %0b expected 0", bus.evt_valid); end
    if (bus.pending !== 4'b0100) begin miscompares++; $display("[TB] FAIL single_pending: got %b expected 0100", bus.pending); end
    tick();
    expId = expQ.pop_front();
    vectors += 3;
    if (bus.evt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid: got %0b expected 1", bus.evt_valid); end
    if (bus.evt_id !== expId) begin miscompares++; $display("[TB] FAIL single_id: got %0d expected %0d", bus.evt_id, expId); end
    if (bus.pending !== 4'b0000) begin miscompares++; $display("[TB] FAIL single_pending_clr: got %b expected 0000", bus.pending); end
    tick();
    vectors++;
    if (bus.evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_after_pop: got %0b expected 0", bus.evt_valid); end
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int burst = 0; burst < 2; burst++) begin
      bus.btn_pulse = 4'b1111;
      for (int b = 0; b < N_BTN; b++) expQ.push_back(2'(b));
      tick();
      bus.btn_pulse = '0;
      vectors++;
      if (bus.pending !== 4'b1111) begin miscompares++; $display("[TB] FAIL rr_pending_set: got %b expected 1111", bus.pending); end
      repeat (4) tick();
      vectors++;
      if (bus.pending !== 4'b0000) begin miscompares++; $display("[TB] FAIL rr_pending_done: got %b expected 0000", bus.pending); end
    end
    drain("rr", 20);
  endtask

  task automatic test_full_fifo();
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int b = 0; b < N_BTN; b++) begin
        bus.btn_pulse = 4'(1 << b);
        expQ.push_back(2'(b));
        tick();
        bus.btn_pulse = '0;
        tick();
        tick();
      end
    end
    bus.btn_pulse = 4'b0011;
    expQ.push_back(2'd0);
    expQ.push_back(2'd1);
    tick();
    bus.btn_pulse = '0;
    tick();
    vectors += 4;
    if (bus.pending !== 4'b0011) begin miscompares++; $display("[TB] FAIL full_pending: got %b expected 0011", bus.pending); end
    if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL full_overflow: got %0b expected 0", bus.overflow); end
    if (bus.evt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL full_valid: got %0b expected 1", bus.evt_valid); end
    if (bus.evt_id !== 2'd0) begin miscompares++; $display("[TB] FAIL full_head: got %0d expected 0", bus.evt_id); end
  endtask

  task automatic test_overflow();
    bus.btn_pulse = 4'b0001;
    tick();
    bus.btn_pulse = '0;
    vectors += 2;
    if (bus.overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_set: got %0b expected 1", bus.overflow); end
    if (bus.pending !== 4'b0011) begin miscompares++; $display("[TB] FAIL ovf_pending: got %b expected 0011", bus.pending); end
    bus.btn_pulse    = 4'b0001;
    bus.clr_overflow = 1'b1;
    tick();
    bus.btn_pulse    = '0;
    bus.clr_overflow = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_set_wins: got %0b expected 1", bus.overflow); end
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_clear: got %0b expected 0", bus.overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [1:0] expId;
    bus.evt_ready = 1'b1;
    expId = expQ.pop_front();
    vectors++;
    if (bus.evt_id !== expId) begin miscompares++; $display("[TB] FAIL pp_head0: got %0d expected %0d", bus.evt_id, expId); end
    tick();
    vectors += 3;
    if (bus.pending !== 4'b0011) begin miscompares++; $display("[TB] FAIL pp_no_push: got %b expected 0011", bus.pending); end
    if (bus.evt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL pp_valid: got %0b expected 1", bus.evt_valid); end
    expId = expQ.pop_front();
    if (bus.evt_id !== expId) begin miscompares++; $display("[TB] FAIL pp_head1: got %0d expected %0d", bus.evt_id, expId); end
    tick();
    vectors++;
    if (bus.pending !== 4'b0010) begin miscompares++; $display("[TB] FAIL pp_push: got %b expected 0010", bus.pending); end
    drain("pp", 40);
    vectors += 2;
    if (bus.evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL pp_empty: got %0b expected 0", bus.evt_valid); end
    if (bus.pending !== 4'b0000) begin miscompares++; $display("[TB] FAIL pp_pending_empty: got %b expected 0000", bus.pending); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] expId;
    do_reset();
    bus.btn_pulse = 4'b0111;
    tick();
    bus.btn_pulse = 4'b0100;
    tick();
    bus.btn_pulse = '0;
    tick();
    tick();
    bus.btn_pulse = 4'b1000;
    tick();
    bus.btn_pulse = '0;
    vectors += 3;
    if (bus.pending !== 4'b1000) begin miscompares++; $display("[TB] FAIL mid_pre_pending: got %b expected 1000", bus.pending); end
    if (bus.overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre_overflow: got %0b expected 1", bus.overflow); end
    if (bus.evt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre_valid: got %0b expected 1", bus.evt_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expQ.delete();
    vectors += 3;
    if (bus.evt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_valid: got %0b expected 0", bus.evt_valid); end
    if (bus.pending !== 4'b0000) begin miscompares++; $display("[TB] FAIL mid_pending: got %b expected 0000", bus.pending); end
    if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_overflow: got %0b expected 0", bus.overflow); end
    repeat (5) tick();
    bus.btn_pulse = 4'b0001;
    expQ.push_back(2'd0);
    tick();
    bus.btn_pulse = '0;
    tick();
    expId = expQ.pop_front();
    vectors += 2;
    if (bus.evt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_new_valid: got %0b expected 1", bus.evt_valid); end
    if (bus.evt_id !== expId) begin miscompares++; $display("[TB] FAIL mid_new_id: got %0d expected %0d", bus.evt_id, expId); end
`ifdef BTN_EVT_TIMESTAMP_EN
    vectors++;
    if (bus.evt_ts !== 16'd5) begin miscompares++; $display("[TB] FAIL mid_new_ts: got %0d expected 5", bus.evt_ts); end
`endif
  endtask

  initial begin
    bus.btn_pulse    = '0;
    bus.evt_ready    = 1'b0;
    bus.clr_overflow = 1'b0;
    $display("[TB] starting button_event_arbiter bench");
    test_reset();
    test_single_press();
    test_round_robin();
    test_full_fifo();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
